// File: rtl/div_pkg.sv
// Shared constants for the sequential divide/modulo unit.
// State encoding and the default operand width.
package div_pkg;

  localparam int DIV_W = 8;

  typedef logic [1:0] div_state_t;

  localparam div_state_t IDLE = 2'd0;
  localparam div_state_t RUN  = 2'd1;
  localparam div_state_t DONE = 2'd2;

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtraction for one restoring-division step.
// A set borrow means the divisor did not fit.
module div_trial_sub
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH:0] rem,
  input  logic [WIDTH:0] dvs,
  output logic [WIDTH:0] diff,
  output logic           borrow
);

  assign diff   = rem - dvs;
  assign borrow = diff[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Start/busy/done handshake; results held until the next completion.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t state, state_nxt;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] r_nxt;
  logic             last;
  logic             dz;

  assign r_sh  = {r, q[WIDTH-1]};
  assign q_nxt = {q[WIDTH-2:0], ~borrow};
  assign r_nxt = borrow ? r_sh[WIDTH-1:0]
                        : diff[WIDTH-1:0];
  assign last  = (cnt == LAST);
  assign dz    = (divisor == '0);

  div_trial_sub #(
    .WIDTH (WIDTH)
  ) u_sub (
    .rem    (r_sh),
    .dvs    ({1'b0, d}),
    .diff   (diff),
    .borrow (borrow)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = dz ? DONE : RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Working registers; the remainder never exceeds WIDTH bits after restore.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q           <= '0;
      r           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !dz) begin
            q   <= dividend;
            r   <= '0;
            d   <= divisor;
            cnt <= '0;
          end else if (start) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end
        end
        RUN: begin
          q   <= q_nxt;
          r   <= r_nxt;
          cnt <= cnt + CW'(1);
          if (last) begin
            quotient    <= q_nxt;
            remainder   <= r_nxt;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
